// File: rtl/frame_seq_pkg.sv
// Shared types for the frame update sequencer: FSM states, the queued cell entry
// and the frame geometry defaults.
package frame_seq_pkg;

    localparam int COLS_DEFAULT = 14;
    localparam int ROWS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        SWAP   = 2'd2,
        REPLAY = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       data;
    } cell_t;

    function automatic logic in_frame(input cell_t c, input int cols, input int rows);
        return (int'(c.x) < cols) && (int'(c.y) < rows);
    endfunction

endpackage

// File: rtl/frame_seq_fifo.sv
// Synchronous show-ahead FIFO with full/empty flags; DEPTH must be a power of two.
module frame_seq_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/frame_update_sequencer.sv
// Queues cell writes from two requesters, writes them to the back buffer, and on
// frame_end swaps buffers and replays the logged writes. Option: FRAME_SEQ_STATS_EN.
module frame_update_sequencer
    import frame_seq_pkg::*;
#(
    parameter int COLS   = COLS_DEFAULT,
    parameter int ROWS   = ROWS_DEFAULT,
    parameter int QDEPTH = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_a_valid,
    output logic       req_a_ready,
    input  logic [7:0] req_a_x,
    input  logic [7:0] req_a_y,
    input  logic       req_a_data,
    input  logic       req_b_valid,
    output logic       req_b_ready,
    input  logic [7:0] req_b_x,
    input  logic [7:0] req_b_y,
    input  logic       req_b_data,
    input  logic       frame_end,
    output logic       wr_en,
    output logic [7:0] wr_x,
    output logic [7:0] wr_y,
    output logic       wr_data,
    output logic       swap,
    output logic       active_buf,
    output logic       busy,
    output seq_state_t dbg_state
`ifdef FRAME_SEQ_STATS_EN
    ,
    output logic [15:0] drop_count
`endif
);
    seq_state_t state;
    cell_t      wr_q;
    cell_t      acc_cell;
    cell_t      q_head;
    cell_t      log_head;
    logic       run_q, rr_b, fe_pend;
    logic       can_acc, acc_a, acc_b, acc_any, acc_ok;
    logic       q_push, q_pop, q_full, q_empty;
    logic       log_push, log_pop, log_full, log_empty;
    logic       go_swap;

    // A request transfers on an edge where valid and ready are both high; ready never
    // depends on the requester's own valid, only on queue space and the other side's turn.
    assign can_acc     = run_q && !q_full;
    assign req_a_ready = can_acc && !(req_b_valid && rr_b);
    assign req_b_ready = can_acc && !(req_a_valid && !rr_b);
    assign acc_a       = req_a_valid && req_a_ready;
    assign acc_b       = req_b_valid && req_b_ready;
    assign acc_any     = acc_a || acc_b;
    assign acc_cell    = acc_a ? cell_t'{req_a_x, req_a_y, req_a_data}
                               : cell_t'{req_b_x, req_b_y, req_b_data};
    assign acc_ok      = in_frame(acc_cell, COLS, ROWS);
    assign q_push      = acc_any && acc_ok;

    // A frame_end (live or pending) outranks a pending pop, but only when there is something to replay.
    assign go_swap  = (state == IDLE) && (frame_end || fe_pend) && !log_empty;
    assign q_pop    = (state == IDLE) && !go_swap && !q_empty && !log_full;
    assign log_push = (state == WRITE);
    assign log_pop  = (state == SWAP) || ((state == REPLAY) && !log_empty);

    assign wr_x      = wr_q.x;
    assign wr_y      = wr_q.y;
    assign wr_data   = wr_q.data;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    frame_seq_fifo #(.W($bits(cell_t)), .DEPTH(QDEPTH)) u_queue (
        .clk(clk), .reset_n(reset_n),
        .push(q_push), .push_data(acc_cell),
        .pop(q_pop), .pop_data(q_head),
        .full(q_full), .empty(q_empty)
    );

    frame_seq_fifo #(.W($bits(cell_t)), .DEPTH(QDEPTH)) u_log (
        .clk(clk), .reset_n(reset_n),
        .push(log_push), .push_data(wr_q),
        .pop(log_pop), .pop_data(log_head),
        .full(log_full), .empty(log_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_en      <= 1'b0;
            wr_q       <= '0;
            swap       <= 1'b0;
            active_buf <= 1'b0;
            fe_pend    <= 1'b0;
            rr_b       <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (acc_a) begin
                rr_b <= 1'b1;
            end else if (acc_b) begin
                rr_b <= 1'b0;
            end
            wr_en <= 1'b0;
            swap  <= 1'b0;
            if (state == IDLE) begin
                fe_pend <= 1'b0;
            end else if (frame_end) begin
                fe_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (go_swap) begin
                        swap       <= 1'b1;
                        active_buf <= ~active_buf;
                        state      <= SWAP;
                    end else if (q_pop) begin
                        wr_en <= 1'b1;
                        wr_q  <= q_head;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                SWAP: begin
                    wr_en <= 1'b1;
                    wr_q  <= log_head;
                    state <= REPLAY;
                end
                REPLAY: begin
                    if (!log_empty) begin
                        wr_en <= 1'b1;
                        wr_q  <= log_head;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FRAME_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (acc_any && !acc_ok && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule
